timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the width of the period and tick counter.
REQ-002 SHALL have parameter PS_WIDTH, default 8, the width of the prescaler.
REQ-003 SHALL have port clock  in  1  system clock, all state on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  in  1  config write strobe.
REQ-006 SHALL have port cfg_period  in  WIDTH  ticks per expiry (N).
REQ-007 SHALL have port cfg_prescale  in  PS_WIDTH  clocks per tick minus 1 (P).
REQ-008 SHALL have port cfg_periodic  in  1  1 = auto-reload, 0 = one-shot.
REQ-009 SHALL have port start  in  1  begin timing from zero.
REQ-010 SHALL have port stop  in  1  abort timing.
REQ-011 SHALL have port irq_ack  in  1  clears irq and overrun.
REQ-012 SHALL have port count  out  WIDTH  current tick count.
REQ-013 SHALL have port busy  out  1  high in RUN.
REQ-014 SHALL have port irq  out  1  sticky expiry flag.
REQ-015 SHALL have port overrun  out  1  sticky missed-ack flag.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and RUN; busy = (state == RUN), registered.
REQ-017 SHALL latch cfg_period, cfg_prescale and cfg_periodic into internal registers when cfg_valid is high in IDLE, and SHALL ignore cfg_valid in RUN.
REQ-018 SHALL move from IDLE to RUN on start when the latched period is nonzero, clearing count and the prescaler to 0; with period 0, start SHALL be ignored.
REQ-019 SHALL, when cfg_valid and start are high in the same IDLE cycle, use the new configuration for that start.
REQ-020 SHALL, in RUN, increment the prescaler each cycle and generate a tick when it equals P; on a tick the prescaler wraps to 0 and count increments.
REQ-021 SHALL expire on a tick with count == N-1: count goes to 0 and irq is set.
REQ-022 SHALL, on expiry, stay in RUN and continue when periodic, and go to IDLE when one-shot.
REQ-023 SHALL, for a start sampled at edge E0, raise irq at edge E0 + N*(P+1) and, when periodic, every N*(P+1) edges thereafter.
REQ-024 SHALL, on stop in RUN, go to IDLE next edge, hold count, clear the prescaler, and not set irq even if the cycle would have expired.
REQ-025 SHALL give stop priority when start and stop are high together; a start in RUN without stop SHALL restart from count 0 and prescaler 0.
REQ-026 SHALL clear irq and overrun on irq_ack, except that an expiry in the same cycle SHALL win and leave irq = 1, overrun unchanged.
REQ-027 SHALL set overrun on an expiry while irq is already 1 and irq_ack is 0.
REQ-028 SHALL compute all counter arithmetic modulo 2^WIDTH / 2^PS_WIDTH without overflow for N up to 2^WIDTH-1 and P up to 2^PS_WIDTH-1.

Reset
REQ-029 SHALL, while reset is high, asynchronously force state IDLE, count 0, prescaler 0, busy 0, irq 0, overrun 0, latched period 0, prescale 0, periodic 0.
REQ-030 SHALL, when reset is asserted mid-RUN, abandon the run; a start after reset with no new cfg_valid SHALL be ignored (period 0).

Verification
REQ-031 SHALL pass: cfg N=3,P=0,one-shot, start at E0 -> irq 1 at E0+3, busy 0 from E0+3, count 0.
REQ-032 SHALL pass: cfg N=2,P=3,periodic, start at E0 -> irq at E0+8; ack; irq again at E0+16; busy stays 1.
REQ-033 SHALL pass: periodic N=1,P=0, no ack -> irq at E0+1, overrun at E0+2; ack at E0+5 coinciding with expiry -> irq stays 1, overrun stays 1.
REQ-034 SHALL pass: N=4,P=1 run, stop in the cycle before expiry -> busy 0, irq 0, count held at 3.
REQ-035 SHALL pass: cfg_valid N=5 during RUN -> ignored, next expiry still at the old period; period 0 start -> busy stays 0.
REQ-036 SHALL pass: reset asserted mid-RUN with irq 1 -> all outputs 0 immediately, not waiting for a clock edge.

Source files
------------

// File: rtl/timer_ctrl.sv
// Programmable tick timer: prescaled tick counter with one-shot/periodic
// expiry, sticky irq and overrun flags, and start/stop control.
module timer_ctrl #(
    parameter int WIDTH    = 16,
    parameter int PS_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [PS_WIDTH-1:0] cfg_prescale,
    input  logic                cfg_periodic,
    input  logic                start,
    input  logic                stop,
    input  logic                irq_ack,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                irq,
    output logic                overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [PS_WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0]    period_q, period_d;
    logic [PS_WIDTH-1:0] prescale_q, prescale_d;
    logic                periodic_q, periodic_d;
    logic                busy_q, busy_d;
    logic                irq_q, irq_d;
    logic                overrun_q, overrun_d;

    logic                tick;
    logic                last;
    logic                expire;
    logic [WIDTH-1:0]    start_period;

    assign tick = (ps_q == prescale_q);
    assign last = (count_q == period_q - WIDTH'(1));

    // A config write in the same cycle as start governs that start.
    assign start_period = cfg_valid ? cfg_period : period_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ps_d       = ps_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        periodic_d = periodic_q;
        irq_d      = irq_q;
        overrun_d  = overrun_q;
        expire     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    period_d   = cfg_period;
                    prescale_d = cfg_prescale;
                    periodic_d = cfg_periodic;
                end
                if (start && !stop && start_period != '0) begin
                    state_d = RUN;
                    count_d = '0;
                    ps_d    = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    ps_d    = '0;
                end else if (start) begin
                    count_d = '0;
                    ps_d    = '0;
                end else if (tick) begin
                    ps_d = '0;
                    if (last) begin
                        expire  = 1'b1;
                        count_d = '0;
                        if (!periodic_q) begin
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    ps_d = ps_q + PS_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // An expiry outranks a coincident acknowledge.
        if (expire) begin
            irq_d = 1'b1;
            if (irq_q && !irq_ack) begin
                overrun_d = 1'b1;
            end
        end else if (irq_ack) begin
            irq_d     = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign busy_d = (state_d == RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            ps_q       <= '0;
            period_q   <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ps_q       <= ps_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            periodic_q <= periodic_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
            overrun_q  <= overrun_d;
        end
    end

    assign count   = count_q;
    assign busy    = busy_q;
    assign irq     = irq_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: expectations are queued per clock edge
// as stimulus is driven and compared when that edge has been reached.
module tb_timer_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_period = '0;
    logic [7:0]  cfg_prescale = '0;
    logic        cfg_periodic = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        irq_ack = 1'b0;
    logic [15:0] count;
    logic        busy;
    logic        irq;
    logic        overrun;

    timer_ctrl #(.WIDTH(16), .PS_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_period   (cfg_period),
        .cfg_prescale (cfg_prescale),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
        .irq_ack      (irq_ack),
        .count        (count),
        .busy         (busy),
        .irq          (irq),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        string       tag;
        logic [15:0] cnt;
        logic        b;
        logic        i;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   e0;

    function automatic void expect_at(int c, string tag, int cnt,
                                      logic b, logic i, logic o);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.cnt = 16'(cnt);
        e.b   = b;
        e.i   = i;
        e.o   = o;
        sb.push_back(e);
    endfunction

    task automatic check_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            assert (count === e.cnt) else begin
                errors++;
                $error("FAIL %s count got %0d expected %0d", e.tag, count, e.cnt);
            end
            checks++;
            assert (busy === e.b) else begin
                errors++;
                $error("FAIL %s busy got %b expected %b", e.tag, busy, e.b);
            end
            checks++;
            assert (irq === e.i) else begin
                errors++;
                $error("FAIL %s irq got %b expected %b", e.tag, irq, e.i);
            end
            checks++;
            assert (overrun === e.o) else begin
                errors++;
                $error("FAIL %s overrun got %b expected %b", e.tag, overrun, e.o);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
        check_due();
    endtask

    task automatic run_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic cfg(int n, int p, logic per);
        cfg_valid    = 1'b1;
        cfg_period   = 16'(n);
        cfg_prescale = 8'(p);
        cfg_periodic = per;
    endtask

    // cfg and start in one cycle; returns with e0 = the start edge
    task automatic cfg_start(int n, int p, logic per);
        cfg(n, p, per);
        start = 1'b1;
        tick();
        e0 = cyc;
        start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic ack_clear(string tag);
        irq_ack = 1'b1;
        expect_at(cyc + 1, tag, int'(count), busy, 1'b0, 1'b0);
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        expect_at(cyc, "rst", 0, 0, 0, 0);
        check_due();
        tick();
        tick();
        reset = 1'b0;

        // one-shot N=3 P=0, config written with start
        cfg_start(3, 0, 1'b0);
        expect_at(e0 + 1, "os_c1", 1, 1, 0, 0);
        expect_at(e0 + 2, "os_c2", 2, 1, 0, 0);
        expect_at(e0 + 3, "os_exp", 0, 0, 1, 0);
        run_to(e0 + 3);
        ack_clear("os_ack");

        // periodic N=2 P=3
        cfg(2, 3, 1'b1);
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        tick();
        e0 = cyc;
        start = 1'b0;
        expect_at(e0 + 7, "p_pre", 1, 1, 0, 0);
        expect_at(e0 + 8, "p_irq1", 0, 1, 1, 0);
        run_to(e0 + 8);
        irq_ack = 1'b1;
        expect_at(e0 + 9, "p_ack", 0, 1, 0, 0);
        tick();
        irq_ack = 1'b0;
        expect_at(e0 + 15, "p_pre2", 1, 1, 0, 0);
        expect_at(e0 + 16, "p_irq2", 0, 1, 1, 0);
        run_to(e0 + 16);
        stop = 1'b1;
        expect_at(e0 + 17, "p_stop", 0, 0, 1, 0);
        tick();
        stop = 1'b0;
        ack_clear("p_clr");

        // periodic N=1 P=0: overrun, then ack colliding with expiry
        cfg_start(1, 0, 1'b1);
        expect_at(e0 + 1, "o_irq", 0, 1, 1, 0);
        expect_at(e0 + 2, "o_ovr", 0, 1, 1, 1);
        run_to(e0 + 4);
        irq_ack = 1'b1;
        expect_at(e0 + 5, "o_ackwin", 0, 1, 1, 1);
        tick();
        irq_ack = 1'b0;
        stop = 1'b1;
        expect_at(e0 + 6, "o_stop", 0, 0, 1, 1);
        tick();
        stop = 1'b0;
        ack_clear("o_clr");

        // N=4 P=1: stop lands on the would-be expiry edge
        cfg_start(4, 1, 1'b0);
        expect_at(e0 + 6, "s_pre", 3, 1, 0, 0);
        run_to(e0 + 7);
        stop = 1'b1;
        expect_at(e0 + 8, "s_stop", 3, 0, 0, 0);
        expect_at(e0 + 10, "s_hold", 3, 0, 0, 0);
        tick();
        stop = 1'b0;
        run_to(e0 + 10);

        // config write while running is ignored
        cfg_start(2, 0, 1'b1);
        cfg(5, 0, 1'b0);
        expect_at(e0 + 2, "c_old", 0, 1, 1, 0);
        expect_at(e0 + 4, "c_old2", 0, 1, 1, 1);
        tick();
        cfg_valid = 1'b0;
        run_to(e0 + 4);
        stop = 1'b1;
        irq_ack = 1'b1;
        expect_at(e0 + 5, "c_stop", 0, 0, 0, 0);
        tick();
        stop = 1'b0;
        irq_ack = 1'b0;

        // period 0 start is ignored
        cfg(0, 0, 1'b1);
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        expect_at(cyc + 1, "z_start", 0, 0, 0, 0);
        tick();
        start = 1'b0;
        tick();

        // start while running restarts from zero
        cfg_start(3, 0, 1'b0);
        run_to(e0 + 1);
        start = 1'b1;
        expect_at(e0 + 2, "r_restart", 0, 1, 0, 0);
        expect_at(e0 + 4, "r_mid", 2, 1, 0, 0);
        expect_at(e0 + 5, "r_exp", 0, 0, 1, 0);
        tick();
        start = 1'b0;
        run_to(e0 + 5);
        ack_clear("r_clr");

        // asynchronous reset mid-run, then start without config
        cfg_start(1, 0, 1'b1);
        expect_at(e0 + 1, "x_irq", 0, 1, 1, 0);
        run_to(e0 + 2);
        #2;
        reset = 1'b1;
        #1;
        expect_at(cyc, "x_async", 0, 0, 0, 0);
        check_due();
        tick();
        reset = 1'b0;
        start = 1'b1;
        expect_at(cyc + 1, "x_nocfg", 0, 0, 0, 0);
        tick();
        start = 1'b0;
        tick();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain pending %0d expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
